// File: rtl/stream_dwc_pkg.sv
// Shared defaults and sizing helpers for the streaming width converters.
// The down-converter uses it now; the matching up-converter will reuse it.
package stream_dwc_pkg;

  localparam int unsigned DWC_IW = 256;
  localparam int unsigned DWC_OW = 32;

  function automatic int unsigned dwc_ratio(input int unsigned wide_w, input int unsigned narrow_w);
    return wide_w / narrow_w;
  endfunction

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned dwc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/streaming_dwc_down_if.sv
// Wide-in / narrow-out stream bundle for the down-converter.
// The master modport is the surrounding environment; slave is the converter.
interface streaming_dwc_down_if
  import stream_dwc_pkg::*;
#(
  parameter int unsigned IW = DWC_IW,
  parameter int unsigned OW = DWC_OW
);

  logic [IW-1:0]                    in_tdata;
  logic                             in_tvalid;
  logic                             in_tready;
  logic [OW-1:0]                    out_tdata;
  logic                             out_tvalid;
  logic                             out_tready;
  logic [dwc_clog2(IW/OW):0]        count;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, count
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, count
  );

endinterface

// File: rtl/streaming_dwc_down.sv
// Serialises one IW-bit word into IW/OW narrow beats, least significant first.
// A new wide word is accepted in the same cycle the last beat leaves.
module streaming_dwc_down
  import stream_dwc_pkg::*;
#(
  parameter int unsigned IW = DWC_IW,
  parameter int unsigned OW = DWC_OW
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [IW-1:0]             in0_V_V_TDATA,
  input  logic                      in0_V_V_TVALID,
  output logic                      in0_V_V_TREADY,
  output logic [OW-1:0]             out_V_V_TDATA,
  output logic                      out_V_V_TVALID,
  input  logic                      out_V_V_TREADY,
  output logic [dwc_clog2(IW/OW):0] count
);

  localparam int unsigned R     = dwc_ratio(IW, OW);
  localparam int unsigned IDX_W = dwc_clog2(R);
  localparam int unsigned CNT_W = dwc_clog2(R) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  logic [IW-1:0]    data_q, data_d;
  logic             full_q, full_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic             in_hs, out_hs, last_beat;
  logic [OW-1:0]    sub_w [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_sub
    assign sub_w[gi] = data_q[gi*OW +: OW];
  end

  assign last_beat      = (idx_q == LAST_IDX);
  assign out_V_V_TDATA  = sub_w[idx_q];
  assign out_V_V_TVALID = full_q;
  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign in0_V_V_TREADY = ap_rst_n & (~full_q | (out_V_V_TREADY & last_beat));
  assign count          = full_q ? (CNT_W'(R) - CNT_W'(idx_q)) : '0;

  assign out_hs = full_q & out_V_V_TREADY;
  assign in_hs  = in0_V_V_TVALID & in0_V_V_TREADY;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    idx_d  = idx_q;
    if (out_hs) begin
      if (last_beat) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    // A load overrides the drain of the last beat, giving back-to-back words.
    if (in_hs) begin
      data_d = in0_V_V_TDATA;
      full_d = 1'b1;
      idx_d  = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
    end
  end

  // Payload needs no reset: it is only observed while full_q is set.
  always_ff @(posedge ap_clk) begin
    data_q <= data_d;
  end

endmodule
